// File: rtl/cla_addsub_pipe_if.sv
// Operand/result handshake bundle for cla_addsub_pipe.
// The master side drives operands and out_ready; the slave side is the adder.
interface cla_addsub_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, in0, in1, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, in0, in1, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: STAGES slices, one per register stage,
// each a two-level (bit/group) lookahead adder, with valid/ready flow control and flags.
module cla_addsub_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned GROUP  = 4,
    parameter int unsigned STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    cla_addsub_pipe_if.slave bus
);
    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned NG = SW / GROUP;

    if ((WIDTH % (GROUP * STAGES)) != 0) begin : g_param_check
        $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP*STAGES");
    end

    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic             r_v   [STAGES];
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    logic [WIDTH-1:0] w_nxt_a   [STAGES];
    logic [WIDTH-1:0] w_nxt_b   [STAGES];
    logic [WIDTH-1:0] w_nxt_sum [STAGES];
    logic             w_nxt_c   [STAGES];
    logic             w_nxt_v   [STAGES];
    logic             w_cmsb    [STAGES];

    logic [WIDTH-1:0] w_b0;
    logic             w_c0;
    logic             w_stall;

    assign w_stall      = r_v[STAGES-1] & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;

    assign w_b0 = bus.sub ? ~bus.in1 : bus.in1;
    assign w_c0 = bus.sub | bus.cin;

    // Pending operands shift down by one slice per stage so the active slice is always
    // at [SW-1:0]; finished sum slices enter at the top and land in place after STAGES.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0] w_sa;
        logic [SW-1:0] w_sb;
        logic [SW-1:0] w_p;
        logic [SW-1:0] w_g;
        logic [SW-1:0] w_s;
        logic [SW:0]   w_c;
        logic [NG-1:0] w_gp;
        logic [NG-1:0] w_gg;
        logic [NG:0]   w_gc;
        logic          w_ci;

        if (k == 0) begin : g_first
            assign w_sa         = bus.in0[SW-1:0];
            assign w_sb         = w_b0[SW-1:0];
            assign w_ci         = w_c0;
            assign w_nxt_v[k]   = bus.in_valid;
            assign w_nxt_a[k]   = bus.in0 >> SW;
            assign w_nxt_b[k]   = w_b0 >> SW;
            assign w_nxt_sum[k] = WIDTH'(w_s) << (WIDTH - SW);
        end else begin : g_later
            assign w_sa         = r_a[k-1][SW-1:0];
            assign w_sb         = r_b[k-1][SW-1:0];
            assign w_ci         = r_c[k-1];
            assign w_nxt_v[k]   = r_v[k-1];
            assign w_nxt_a[k]   = r_a[k-1] >> SW;
            assign w_nxt_b[k]   = r_b[k-1] >> SW;
            assign w_nxt_sum[k] = (r_sum[k-1] >> SW) | (WIDTH'(w_s) << (WIDTH - SW));
        end

        assign w_p = w_sa ^ w_sb;
        assign w_g = w_sa & w_sb;

        always_comb begin : group_pg
            logic t;
            w_gp = '0;
            w_gg = '0;
            for (int unsigned j = 0; j < NG; j++) begin
                w_gp[j] = &w_p[j*GROUP +: GROUP];
                for (int unsigned i = 0; i < GROUP; i++) begin
                    t = w_g[j*GROUP + i];
                    for (int unsigned m = i + 1; m < GROUP; m++) t = t & w_p[j*GROUP + m];
                    w_gg[j] = w_gg[j] | t;
                end
            end
        end

        always_comb begin : group_carry
            logic acc;
            logic t;
            w_gc    = '0;
            w_gc[0] = w_ci;
            for (int unsigned j = 0; j < NG; j++) begin
                acc = w_ci;
                for (int unsigned u = 0; u <= j; u++) acc = acc & w_gp[u];
                for (int unsigned i = 0; i <= j; i++) begin
                    t = w_gg[i];
                    for (int unsigned u = i + 1; u <= j; u++) t = t & w_gp[u];
                    acc = acc | t;
                end
                w_gc[j+1] = acc;
            end
        end

        always_comb begin : bit_carry
            logic acc;
            logic t;
            w_c = '0;
            for (int unsigned j = 0; j < NG; j++) begin
                for (int unsigned i = 0; i < GROUP; i++) begin
                    acc = w_gc[j];
                    for (int unsigned u = 0; u < i; u++) acc = acc & w_p[j*GROUP + u];
                    for (int unsigned m = 0; m < i; m++) begin
                        t = w_g[j*GROUP + m];
                        for (int unsigned u = m + 1; u < i; u++) t = t & w_p[j*GROUP + u];
                        acc = acc | t;
                    end
                    w_c[j*GROUP + i] = acc;
                end
            end
            w_c[SW] = w_gc[NG];
        end

        assign w_s        = w_p ^ w_c[SW-1:0];
        assign w_nxt_c[k] = w_c[SW];
        assign w_cmsb[k]  = w_c[SW-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
                r_v[k]   <= 1'b0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (!w_stall) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_a[k]   <= w_nxt_a[k];
                r_b[k]   <= w_nxt_b[k];
                r_sum[k] <= w_nxt_sum[k];
                r_c[k]   <= w_nxt_c[k];
                r_v[k]   <= w_nxt_v[k];
            end
            r_ovf  <= w_cmsb[STAGES-1] ^ w_nxt_c[STAGES-1];
            r_zero <= ~|w_nxt_sum[STAGES-1];
            r_neg  <= w_nxt_sum[STAGES-1][WIDTH-1];
        end
    end

    assign bus.out_valid = r_v[STAGES-1];
    assign bus.sum       = r_sum[STAGES-1];
    assign bus.cout      = r_c[STAGES-1];
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: directed cases on 16/4/2, random streams on 16/4/2, 32/4/4
// and 8/2/1 against an arithmetic reference, plus backpressure and reset flush.
module tb_cla_addsub_pipe;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cla_addsub_pipe_if #(.WIDTH(16)) if16 ();
    cla_addsub_pipe_if #(.WIDTH(32)) if32 ();
    cla_addsub_pipe_if #(.WIDTH(8))  if8 ();

    cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .STAGES(2)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    cla_addsub_pipe #(.WIDTH(32), .GROUP(4), .STAGES(4)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    cla_addsub_pipe #(.WIDTH(8),  .GROUP(2), .STAGES(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8));

    function automatic int wid(input int cfg);
        return (cfg == 0) ? 16 : (cfg == 1) ? 32 : 8;
    endfunction

    function automatic int lat_of(input int cfg);
        return (cfg == 0) ? 2 : (cfg == 1) ? 4 : 1;
    endfunction

    function automatic res_t mk(input logic [31:0] s, input logic c, v, z, n);
        res_t r;
        r.sum = s; r.cout = c; r.ovf = v; r.zero = z; r.neg = n;
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("sum=%h cout=%b ovf=%b zero=%b neg=%b", r.sum, r.cout, r.ovf, r.zero, r.neg);
    endfunction

    // Reference: plain modular arithmetic on a wide integer; overflow from operand/result signs.
    function automatic res_t model(input int w, input logic [31:0] a, b, input logic ci, s);
        longint unsigned m, aa, bb, bp, full;
        res_t r;
        m    = (64'd1 << w) - 1;
        aa   = a & m;
        bb   = b;
        bp   = s ? (~bb & m) : (bb & m);
        full = aa + bp + (s ? 64'd1 : longint'(ci));
        r.sum  = 32'(full & m);
        r.cout = full[w];
        r.ovf  = (aa[w-1] == bp[w-1]) && (full[w-1] != aa[w-1]);
        r.zero = ((full & m) == 0);
        r.neg  = full[w-1];
        return r;
    endfunction

    task automatic drive(input int cfg, input logic v, input logic [31:0] a, b,
                         input logic ci, s, ordy);
        case (cfg)
            0: begin
                if16.in_valid = v; if16.in0 = a[15:0]; if16.in1 = b[15:0];
                if16.cin = ci; if16.sub = s; if16.out_ready = ordy;
            end
            1: begin
                if32.in_valid = v; if32.in0 = a; if32.in1 = b;
                if32.cin = ci; if32.sub = s; if32.out_ready = ordy;
            end
            default: begin
                if8.in_valid = v; if8.in0 = a[7:0]; if8.in1 = b[7:0];
                if8.cin = ci; if8.sub = s; if8.out_ready = ordy;
            end
        endcase
    endtask

    task automatic sample(input int cfg, output logic ir, ov, output res_t r);
        case (cfg)
            0: begin
                ir = if16.in_ready; ov = if16.out_valid;
                r = mk(32'(if16.sum), if16.cout, if16.ovf, if16.zero, if16.neg);
            end
            1: begin
                ir = if32.in_ready; ov = if32.out_valid;
                r = mk(if32.sum, if32.cout, if32.ovf, if32.zero, if32.neg);
            end
            default: begin
                ir = if8.in_ready; ov = if8.out_valid;
                r = mk(32'(if8.sum), if8.cout, if8.ovf, if8.zero, if8.neg);
            end
        endcase
    endtask

    // Single beat into an idle pipe; returns the result and the cycles until out_valid.
    task automatic do_op(input int cfg, input logic [31:0] a, b, input logic ci, s,
                         output res_t r, output int lat);
        logic ir, ov;
        res_t cur;
        bit   found;
        found = 0; r = '0; lat = -1;
        @(negedge clk);
        drive(cfg, 1'b1, a, b, ci, s, 1'b1);
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge clk);
            drive(cfg, 1'b0, a, b, ci, s, 1'b1);
            #1;
            sample(cfg, ir, ov, cur);
            if (ov === 1'b1) begin
                found = 1; r = cur; lat = i;
            end
        end
    endtask

    // mode 0: random valid/ready; mode 1: back-to-back beats, out_ready low on cycles 4..6.
    task automatic stream(input int cfg, input int n, input int mode, output int stalls);
        res_t  q[$];
        res_t  cur, prev, exp_r;
        logic  ir, ov, v, ci, s, ordy, pstall;
        logic [31:0] a, b;
        int    sent, got, cyc;
        sent = 0; got = 0; cyc = 0; stalls = 0; pstall = 0; prev = '0;
        while ((sent < n || got < sent) && cyc < n * 8 + 50) begin
            @(negedge clk);
            cyc++;
            v    = (sent < n) && (mode == 1 || $urandom_range(3) != 0);
            a    = $urandom;
            b    = $urandom;
            ci   = 1'($urandom_range(1));
            s    = 1'($urandom_range(1));
            ordy = (mode == 1) ? !(cyc >= 4 && cyc <= 6) : ($urandom_range(4) != 0);
            drive(cfg, v, a, b, ci, s, ordy);
            #1;
            sample(cfg, ir, ov, cur);
            total++;
            if (ir !== !(ov && !ordy)) begin
                bad++;
                $display("FAIL in_ready cfg=%0d cyc=%0d got %b want %b", cfg, cyc, ir, !(ov && !ordy));
            end
            if (pstall) begin
                total++;
                if (ov !== 1'b1 || cur !== prev) begin
                    bad++;
                    $display("FAIL hold cfg=%0d cyc=%0d got v=%b %s want v=1 %s", cfg, cyc, ov, fmt(cur), fmt(prev));
                end
            end
            if (ov === 1'b1 && ordy) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat cfg=%0d cyc=%0d got %s want none", cfg, cyc, fmt(cur));
                end else begin
                    exp_r = q.pop_front();
                    if (cur !== exp_r) begin
                        bad++;
                        $display("FAIL result cfg=%0d beat=%0d got %s want %s", cfg, got, fmt(cur), fmt(exp_r));
                    end
                end
                got++;
            end
            if (v && ir === 1'b1) begin
                q.push_back(model(wid(cfg), a, b, ci, s));
                sent++;
            end
            if (v && ir !== 1'b1) stalls++;
            pstall = (ov === 1'b1) && !ordy;
            prev   = cur;
        end
        total++;
        if (got != n || sent != n) begin
            bad++;
            $display("FAIL beat_count cfg=%0d got sent=%0d recv=%0d want %0d", cfg, sent, got, n);
        end
        @(negedge clk);
        drive(cfg, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        logic ir, ov;
        res_t r;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) drive(c, 1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            sample(c, ir, ov, r);
            total++;
            if (ov !== 1'b0 || r !== '0) begin
                bad++;
                $display("FAIL reset_outputs cfg=%0d got v=%b %s want v=0 all zero", c, ov, fmt(r));
            end
        end
        for (int c = 0; c < 3; c++) drive(c, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            sample(c, ir, ov, r);
            total++;
            if (ir !== 1'b1) begin
                bad++;
                $display("FAIL ready_after_reset cfg=%0d got %b want 1", c, ir);
            end
        end
    endtask

    task automatic test_add_carry();
        res_t r;
        int   lat;
        do_op(0, 32'h00FF, 32'h0001, 1'b1, 1'b0, r, lat);
        total++;
        if (r !== mk(32'h0101, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL add_carry got %s want %s", fmt(r), fmt(mk(32'h0101, 0, 0, 0, 0)));
        end
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL add_latency got %0d want 2", lat);
        end
    endtask

    task automatic test_wrap();
        res_t r;
        int   lat;
        do_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, r, lat);
        total++;
        if (r !== mk(32'h0000, 1, 0, 1, 0)) begin
            bad++;
            $display("FAIL wrap_zero got %s want %s", fmt(r), fmt(mk(32'h0000, 1, 0, 1, 0)));
        end
        do_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, r, lat);
        total++;
        if (r !== mk(32'h8000, 0, 1, 0, 1)) begin
            bad++;
            $display("FAIL wrap_ovf got %s want %s", fmt(r), fmt(mk(32'h8000, 0, 1, 0, 1)));
        end
    endtask

    task automatic test_subtract();
        res_t r;
        int   lat;
        do_op(0, 32'h0005, 32'h0007, 1'b0, 1'b1, r, lat);
        total++;
        if (r !== mk(32'hFFFE, 0, 0, 0, 1)) begin
            bad++;
            $display("FAIL sub_borrow got %s want %s", fmt(r), fmt(mk(32'hFFFE, 0, 0, 0, 1)));
        end
        do_op(0, 32'h8000, 32'h0001, 1'b1, 1'b1, r, lat);
        total++;
        if (r !== mk(32'h7FFF, 1, 1, 0, 0)) begin
            bad++;
            $display("FAIL sub_ovf got %s want %s", fmt(r), fmt(mk(32'h7FFF, 1, 1, 0, 0)));
        end
    endtask

    task automatic test_latency();
        res_t r, e;
        int   lat;
        logic [31:0] a, b;
        logic ci, s;
        for (int c = 0; c < 3; c++) begin
            a = $urandom; b = $urandom; ci = 1'($urandom_range(1)); s = 1'($urandom_range(1));
            e = model(wid(c), a, b, ci, s);
            do_op(c, a, b, ci, s, r, lat);
            total++;
            if (lat !== lat_of(c)) begin
                bad++;
                $display("FAIL latency cfg=%0d got %0d want %0d", c, lat, lat_of(c));
            end
            total++;
            if (r !== e) begin
                bad++;
                $display("FAIL latency_result cfg=%0d got %s want %s", c, fmt(r), fmt(e));
            end
        end
    endtask

    task automatic test_backpressure();
        int stalls;
        stream(0, 6, 1, stalls);
        total++;
        if (stalls !== 3) begin
            bad++;
            $display("FAIL stall_cycles got %0d want 3", stalls);
        end
    endtask

    task automatic test_random();
        int stalls;
        for (int c = 0; c < 3; c++) stream(c, 1000, 0, stalls);
    endtask

    task automatic test_reset_flush();
        logic ir, ov;
        res_t r, e;
        int   lat;
        bit   seen [3];
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) drive(c, 1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        for (int c = 0; c < 3; c++) drive(c, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            sample(c, ir, ov, r);
            total++;
            if (ov !== 1'b0 || r !== '0) begin
                bad++;
                $display("FAIL flush_async cfg=%0d got v=%b %s want v=0 all zero", c, ov, fmt(r));
            end
            seen[c] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            for (int c = 0; c < 3; c++) begin
                sample(c, ir, ov, r);
                if (ov !== 1'b0) seen[c] = 1;
            end
        end
        for (int c = 0; c < 3; c++) begin
            total++;
            if (seen[c]) begin
                bad++;
                $display("FAIL flush_leak cfg=%0d got stale out_valid want none", c);
            end
        end
        e = model(16, 32'h1234, 32'h4321, 1'b0, 1'b1);
        do_op(0, 32'h1234, 32'h4321, 1'b0, 1'b1, r, lat);
        total++;
        if (r !== e) begin
            bad++;
            $display("FAIL after_flush got %s want %s", fmt(r), fmt(e));
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_wrap();
        test_subtract();
        test_latency();
        test_backpressure();
        test_random();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
